sysid_checker: RTL and testbench

- Avalon-MM read master placed directly upstream of the system-ID slave (2-word space: addr 0 = system ID, addr 1 = build timestamp).
- After reset, or on request, it reads both words and compares them against build-time expected values.
- Sets sticky pass/fail status consumed by boot/supervisor logic, so the rover firmware never runs against a mismatched FPGA image.

---
 rtl/sysid_checker_if.sv | 13 +
 rtl/sysid_checker.sv | 130 +++++++++++++
 tb/tb_sysid_checker.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only link between the sysid checker (master) and the
// two-word system-ID slave.
interface sysid_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (output avm_address, avm_read,
                  input  avm_waitrequest, avm_readdata);
  modport slave  (input  avm_address, avm_read,
                  output avm_waitrequest, avm_readdata);
endinterface

// File: rtl/sysid_checker.sv
// Reads the system ID and build timestamp from the sysid slave and latches
// sticky pass/fail status so boot logic can refuse a mismatched FPGA image.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1568996551,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  sysid_checker_if.master        avm,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   id_mismatch,
  output logic                   ts_mismatch,
  output logic                   timeout_err,
  output logic [31:0]            id_value,
  output logic [31:0]            ts_value
);
  typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, EVAL, DONE} state_e;

  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

  state_e      state_q;
  logic        first_q, read_q, addr_q;
  logic        busy_q, done_q, pass_q, idm_q, tsm_q, tmo_err_q;
  logic [31:0] id_q, ts_q;
  logic [15:0] tmo_q;
  logic [3:0]  retry_q;
  logic        go;

  // first_q marks the first clock after reset release for auto-start
  assign go = start || (state_q == IDLE && first_q && AUTO_START);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      first_q   <= 1'b1;
      read_q    <= 1'b0;
      addr_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      idm_q     <= 1'b0;
      tsm_q     <= 1'b0;
      tmo_err_q <= 1'b0;
      id_q      <= '0;
      ts_q      <= '0;
      tmo_q     <= '0;
      retry_q   <= '0;
    end else begin
      first_q <= 1'b0;
      case (state_q)
        IDLE, DONE: if (go) begin
          state_q   <= RD_ID;
          read_q    <= 1'b1;
          addr_q    <= 1'b0;
          busy_q    <= 1'b1;
          done_q    <= 1'b0;
          pass_q    <= 1'b0;
          idm_q     <= 1'b0;
          tsm_q     <= 1'b0;
          tmo_err_q <= 1'b0;
          id_q      <= '0;
          ts_q      <= '0;
          tmo_q     <= '0;
          retry_q   <= '0;
        end
        RD_ID, RD_TS: begin
          if (!read_q) begin
            // one idle cycle on the bus after a timed-out attempt
            read_q <= 1'b1;
          end else if (!avm.avm_waitrequest) begin
            tmo_q <= '0;
            if (state_q == RD_ID) begin
              id_q    <= avm.avm_readdata;
              addr_q  <= 1'b1;
              state_q <= RD_TS;
            end else begin
              ts_q    <= avm.avm_readdata;
              read_q  <= 1'b0;
              addr_q  <= 1'b0;
              state_q <= EVAL;
            end
          end else if (tmo_q == TMO_LAST) begin
            tmo_q  <= '0;
            read_q <= 1'b0;
            addr_q <= 1'b0;
            if (retry_q == RETRY_MAX) begin
              tmo_err_q <= 1'b1;
              pass_q    <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= DONE;
            end else begin
              retry_q <= retry_q + 4'd1;
              state_q <= RD_ID;
            end
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        EVAL: begin
          idm_q   <= (id_q != EXPECTED_ID);
          tsm_q   <= (ts_q != EXPECTED_TS);
          pass_q  <= (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS);
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign avm.avm_address = addr_q;
  assign avm.avm_read    = read_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign id_mismatch     = idm_q;
  assign ts_mismatch     = tsm_q;
  assign timeout_err     = tmo_err_q;
  assign id_value        = id_q;
  assign ts_value        = ts_q;
endmodule

// File: tb/tb_sysid_checker.sv
// Scoreboard bench for sysid_checker: a stalling slave model, a run-level
// outcome model, and a monitor that checks each completed check.
module tb_sysid_checker;
  localparam logic [31:0] EXP_ID  = 32'd0;
  localparam logic [31:0] EXP_TS  = 32'd1568996551;
  localparam int          TMO     = 4;
  localparam int          RETRIES = 1;

  logic clock = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic busy, done, pass, id_mismatch, ts_mismatch, timeout_err;
  logic [31:0] id_value, ts_value;

  sysid_checker_if avm();

  sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .TIMEOUT_CYCLES(TMO),
    .MAX_RETRIES(RETRIES), .AUTO_START(1'b1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .avm(avm),
    .busy(busy), .done(done), .pass(pass), .id_mismatch(id_mismatch),
    .ts_mismatch(ts_mismatch), .timeout_err(timeout_err),
    .id_value(id_value), .ts_value(ts_value)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int vectors = 0, errors = 0;

  typedef struct {
    int          done_cyc;
    int          reads;
    bit          pass, idm, tsm, tmo;
    logic [31:0] idv, tsv;
  } exp_t;
  exp_t q[$];

  // slave plan for the current run
  logic [31:0] word [2];
  int          stall_left [2];
  bit          stall_forever = 1'b0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Outcome of one check run from the block's rules: each word costs one
  // cycle plus its stalls, then one evaluation cycle; a permanent stall
  // burns every attempt of TMO read cycles with a one-cycle gap between.
  function automatic exp_t model(int e, bit fs, int s0, int s1,
                                 logic [31:0] w0, logic [31:0] w1);
    exp_t x;
    if (fs) begin
      x.tmo = 1'b1; x.pass = 1'b0; x.idm = 1'b0; x.tsm = 1'b0;
      x.idv = '0;   x.tsv = '0;
      x.reads    = (RETRIES + 1) * TMO;
      x.done_cyc = e + (RETRIES + 1) * TMO + RETRIES;
    end else begin
      x.tmo  = 1'b0;
      x.idm  = (w0 != EXP_ID);
      x.tsm  = (w1 != EXP_TS);
      x.pass = !x.idm && !x.tsm;
      x.idv  = w0; x.tsv = w1;
      x.reads    = 2 + s0 + s1;
      x.done_cyc = e + 3 + s0 + s1;
    end
    return x;
  endfunction

  task automatic issue(bit fs, int s0, int s1, logic [31:0] w0, logic [31:0] w1, int e);
    stall_forever = fs;
    stall_left[0] = s0; stall_left[1] = s1;
    word[0] = w0;       word[1] = w1;
    q.push_back(model(e, fs, s0, s1, w0, w1));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(done && q.size() == 0) && n < 200) begin
      @(negedge clock); n++;
    end
    if (n >= 200) begin
      vectors++; errors++;
      $display("FAIL wait_idle: done=%0b pending=%0d, expected done=1 pending=0", done, q.size());
    end
  endtask

  task automatic run(bit fs, int s0, int s1, logic [31:0] w0, logic [31:0] w1, bit busy_start);
    wait_idle();
    @(negedge clock);
    issue(fs, s0, s1, w0, w1, cyc + 1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("clr_busy", busy, 1);
    check("clr_done", done, 0);
    check("clr_pass", pass, 0);
    check("clr_tmo",  timeout_err, 0);
    check("clr_idm",  id_mismatch, 0);
    if (busy_start) begin
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
  endtask

  task automatic check_zero(string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_idm"},  id_mismatch, 0);
    check({tag, "_tsm"},  ts_mismatch, 0);
    check({tag, "_tmo"},  timeout_err, 0);
    check({tag, "_idv"},  id_value, 0);
    check({tag, "_tsv"},  ts_value, 0);
    check({tag, "_rd"},   avm.avm_read, 0);
    check({tag, "_addr"}, avm.avm_address, 0);
  endtask

  // sysid slave model: waitrequest/readdata change only on the falling edge
  initial begin
    logic a;
    avm.avm_waitrequest = 1'b0;
    avm.avm_readdata    = '0;
    forever begin
      @(negedge clock);
      if (avm.avm_read) begin
        a = avm.avm_address;
        if (stall_forever || stall_left[a] > 0) begin
          avm.avm_waitrequest = 1'b1;
          avm.avm_readdata    = '0;
          if (!stall_forever) stall_left[a]--;
        end else begin
          avm.avm_waitrequest = 1'b0;
          avm.avm_readdata    = word[a];
        end
      end else begin
        avm.avm_waitrequest = 1'b0;
      end
    end
  end

  // monitor: each rising done retires one scoreboard entry
  initial begin
    bit   dprev = 1'b0;
    int   rd = 0;
    exp_t x;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        dprev = 1'b0; rd = 0;
      end else begin
        if (avm.avm_read) rd++;
        if (done && !dprev) begin
          if (q.size() == 0) begin
            vectors++; errors++;
            $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
          end else begin
            x = q.pop_front();
            check("done_cycle", cyc, x.done_cyc);
            check("reads",      rd, x.reads);
            check("busy",       busy, 0);
            check("pass",       pass, x.pass);
            check("id_mm",      id_mismatch, x.idm);
            check("ts_mm",      ts_mismatch, x.tsm);
            check("timeout",    timeout_err, x.tmo);
            check("id_value",   id_value, x.idv);
            check("ts_value",   ts_value, x.tsv);
          end
          rd = 0;
        end
        dprev = done;
      end
    end
  end

  initial begin
    int          n;
    bit          fs, bs;
    int          s0, s1;
    logic [31:0] w0, w1;

    repeat (3) @(negedge clock);
    check_zero("rst");

    // auto-start after release, zero-wait matching slave
    issue(1'b0, 0, 0, EXP_ID, EXP_TS, cyc + 1);
    reset_n = 1'b1;

    run(1'b0, 0, 0, 32'h1, EXP_TS, 1'b0);
    run(1'b1, 0, 0, EXP_ID, EXP_TS, 1'b0);
    run(1'b0, 0, 0, EXP_ID, EXP_TS, 1'b1);
    run(1'b0, 2, 1, EXP_ID, 32'hDEAD_BEEF, 1'b1);

    // reset while reading the timestamp
    wait_idle();
    @(negedge clock);
    issue(1'b0, 0, 2, 32'hA5A5_0001, EXP_TS, cyc + 1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (!(avm.avm_read && avm.avm_address) && n < 20) begin
      @(negedge clock); n++;
    end
    if (n >= 20) begin
      vectors++; errors++;
      $display("FAIL reach_rd_ts: got no timestamp read, expected one within 20 cycles");
    end
    #1 reset_n = 1'b0;
    #1 check_zero("midrst");
    q.delete();
    @(negedge clock);
    issue(1'b0, 0, 0, EXP_ID, EXP_TS, cyc + 1);
    reset_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      fs = ($urandom_range(0, 4) == 0);
      s0 = $urandom_range(0, TMO - 1);
      s1 = $urandom_range(0, TMO - 1);
      w0 = ($urandom_range(0, 1) == 1) ? EXP_ID : 32'($urandom);
      w1 = ($urandom_range(0, 1) == 1) ? EXP_TS : 32'($urandom);
      bs = ($urandom_range(0, 1) == 1);
      run(fs, s0, s1, w0, w1, bs);
    end

    wait_idle();
    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
